// File: rtl/display_pkg.sv
// Shared state encoding and seven-segment patterns for the display scanner.
// Segment patterns are active-high, ordered {g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_e;

  localparam int DISPLAY_TICK_HZ = 200;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational BCD to seven-segment decoder; non-decimal codes render a dash.
module seven_segment_decoder
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // NOTE: every path through a combinational block must assign each output
  // (here via the case default); a missing path infers a latch.
  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed seven-segment scanner: one digit per display-clock rising
// edge, a blanking gap between digits, and a per-frame snapshot of the inputs.
module display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 1000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    cmosClock,
  input  logic                    reset,
  input  logic                    displayClock,
  input  logic [4*NUM_DIGITS-1:0] digitsIn,
  input  logic [NUM_DIGITS-1:0]   digitEnable,
  input  logic [NUM_DIGITS-1:0]   decimalPoints,
  output logic [NUM_DIGITS-1:0]   anodeOut,
  output logic [6:0]              segmentOut,
  output logic                    dpOut,
  output logic                    frameStart
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_POL = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_POL   = {7{ACTIVE_LOW}};

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                    frame_start_q, frame_start_d;
  logic                    dclk_prev_q;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic       tick;
  logic       latch_snapshot;
  logic [3:0] nibble;
  logic [6:0] seg_raw;

  // displayClock comes from another counter and is treated purely as data.
  assign tick = displayClock & ~dclk_prev_q;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    latch_snapshot = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          latch_snapshot = 1'b1;
          idx_d          = '0;
          cnt_d          = '0;
          state_d        = BLANK;
        end
      end
      BLANK: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHOW: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = BLANK;
          if (idx_q == LAST_IDX) begin
            idx_d          = '0;
            latch_snapshot = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign snap_digits_d = latch_snapshot ? digitsIn      : snap_digits_q;
  assign snap_en_d     = latch_snapshot ? digitEnable   : snap_en_q;
  assign snap_dp_d     = latch_snapshot ? decimalPoints : snap_dp_q;
  assign frame_start_d = latch_snapshot;

  assign nibble = snap_digits_q[{idx_q, 2'b00} +: 4];

  seven_segment_decoder u_decoder (
    .bcd_i (nibble),
    .seg_o (seg_raw)
  );

  // Disabled digits keep their anode slot so every digit gets equal on-time.
  always_comb begin
    anode_d = '0;
    seg_d   = SEG_OFF;
    dp_d    = 1'b0;
    if (state_q == SHOW) begin
      anode_d = NUM_DIGITS'(1) << idx_q;
      if (snap_en_q[idx_q]) begin
        seg_d = seg_raw;
        dp_d  = snap_dp_q[idx_q];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge cmosClock) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      // NOTE: the snapshot is reset too, so nothing stale survives a reset
      // even though it is always reloaded before being displayed.
      snap_digits_q <= '0;
      snap_en_q     <= '0;
      snap_dp_q     <= '0;
      frame_start_q <= 1'b0;
      dclk_prev_q   <= 1'b1;
      anode_q       <= ANODE_POL;
      seg_q         <= SEG_POL;
      dp_q          <= ACTIVE_LOW;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      snap_digits_q <= snap_digits_d;
      snap_en_q     <= snap_en_d;
      snap_dp_q     <= snap_dp_d;
      frame_start_q <= frame_start_d;
      dclk_prev_q   <= displayClock;
      anode_q       <= anode_d ^ ANODE_POL;
      seg_q         <= seg_d ^ SEG_POL;
      dp_q          <= dp_d ^ ACTIVE_LOW;
    end
  end

  assign anodeOut   = anode_q;
  assign segmentOut = seg_q;
  assign dpOut      = dp_q;
  assign frameStart = frame_start_q;

endmodule
